// File: rtl/dmem_arbiter_if.sv
// Data-memory sharing bus: CPU port, external requester port and memory port.
// The arbiter takes the slave view; the surrounding system (CPU, loader, RAM)
// takes the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // CPU side
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // External requester side
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU datapath and an external
// requester. The CPU has default priority; after STARVE_LIMIT consecutive
// blocked external cycles the external side gets a burst of up to BURST_MAX
// grants (stalling the CPU), followed by one cool-down cycle for the CPU.
// Optional macro DMEM_ARB_STATS_EN adds saturating stall/grant counters.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 16
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [7:0]     stat_stall,
  output logic [7:0]     stat_ext
`endif
);

  localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int BURST_W = $clog2(BURST_MAX + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_EXT  = 2'd1,
    S_COOL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0]  ext_rdata_q;
  logic               ext_rvalid_q;

  logic               ext_gnt;
  logic               cpu_stall;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [DATA_W-1:0]  mem_wdata_c;
  logic               mem_we_c;

  // Next-state, counter updates and grant/stall decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    ext_gnt     = 1'b0;
    cpu_stall   = 1'b0;

    unique case (state_q)
      S_CPU: begin
        ext_gnt = bus.ext_req & ~bus.cpu_req;
        if (bus.ext_req && bus.cpu_req) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = S_EXT;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end

      S_EXT: begin
        ext_gnt    = bus.ext_req;
        // When the requester drops out, this cycle goes back to the CPU.
        cpu_stall  = bus.cpu_req & bus.ext_req;
        wait_cnt_d = '0;
        if (bus.ext_req) begin
          if (burst_cnt_q == BURST_LAST) begin
            state_d     = S_COOL;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else begin
          state_d     = S_CPU;
          burst_cnt_d = '0;
        end
      end

      S_COOL: begin
        wait_cnt_d  = '0;
        burst_cnt_d = '0;
        state_d     = S_CPU;
      end

      default: begin
        wait_cnt_d  = '0;
        burst_cnt_d = '0;
        state_d     = S_CPU;
      end
    endcase

    // Nothing may reach the memory or the CPU while reset is held.
    if (rst) begin
      ext_gnt   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  // Memory port mux: the external side drives the port only on a grant.
  always_comb begin
    mem_addr_c  = bus.cpu_addr;
    mem_wdata_c = bus.cpu_wdata;
    mem_we_c    = bus.cpu_req & bus.cpu_we & ~cpu_stall;
    if (ext_gnt) begin
      mem_addr_c  = bus.ext_addr;
      mem_wdata_c = bus.ext_wdata;
      mem_we_c    = bus.ext_we;
    end
    if (rst) begin
      mem_we_c = 1'b0;
    end
  end

  // State, counters and the registered external read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CPU;
      wait_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      if (ext_gnt && !bus.ext_we) begin
        ext_rvalid_q <= 1'b1;
        ext_rdata_q  <= bus.mem_rdata;
      end else begin
        ext_rvalid_q <= 1'b0;
      end
    end
  end

  assign bus.ext_gnt    = ext_gnt;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.mem_we     = mem_we_c;

`ifdef DMEM_ARB_STATS_EN
  logic [7:0] stat_stall_q;
  logic [7:0] stat_ext_q;

  // Saturating counters of CPU stall cycles and external grant cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_q <= '0;
      stat_ext_q   <= '0;
    end else begin
      if (cpu_stall && stat_stall_q != 8'hFF) stat_stall_q <= stat_stall_q + 8'd1;
      if (ext_gnt && stat_ext_q != 8'hFF)     stat_ext_q   <= stat_ext_q + 8'd1;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_ext   = stat_ext_q;
`endif

endmodule
